vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Video timing generator and pixel fetcher downstream of the VRAM read port of the memory block.
- Produces 640x480@60 VGA timing on the pixel clock, generates VRAM word addresses for a 128x120 framebuffer (4x scaled to 512x480, centred), and converts the returned 16-bit words to RGB.
- Compensates for the VRAM port's one-cycle registered-address latency by delaying sync/blank to match the pixel data.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch
- IMG_X_OFF, 64, first visible column of the image window; the window spans 512 columns

Ports:
- vclk  input  1  pixel clock (25 MHz); the same clock drives the VRAM read port
- rst  input  1  asynchronous, active-low reset (0 = reset)
- en  input  1  scan enable; when 0, counters hold and outputs blank
- border  input  15  colour {R5,G5,B5} shown in visible area outside the image window
- vaddr  output  16  VRAM read address {2'b11, row[6:0], col[6:0]}
- vout  input  16  VRAM data, valid one vclk after vaddr is sampled
- vga_hs  output  1  hsync, active-low
- vga_vs  output  1  vsync, active-low
- vga_r, vga_g, vga_b  output  5 each  pixel colour
- blank  output  1  1 outside the visible area
- frame_start  output  1  one-cycle pulse at the first visible pixel output of each frame

Behaviour:
- Reset (rst=0, asynchronous): hcnt=0, vcnt=0, vga_hs=1, vga_vs=1, blank=1, RGB=0, frame_start=0, vaddr=16'hC000. All pipeline registers are cleared. Operation resumes at hcnt=0, vcnt=0 on the first vclk after release.
- Counters:
  - hcnt runs 0..H_TOTAL-1 (800). At wrap, hcnt returns to 0 and vcnt increments.
  - vcnt runs 0..V_TOTAL-1 (525), then wraps to 0.
  - Totals are the sums of the respective parameters.
  - When en=0, both counters hold.
- Stage 0 (combinational from the counters):
  - vis = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE).
  - win = vis && hcnt>=IMG_X_OFF && hcnt<IMG_X_OFF+512.
  - col = (hcnt-IMG_X_OFF)>>2, row = vcnt>>2.
  - vaddr = {2'b11, row[6:0], col[6:0]} (row*128+col). Outside the window, vaddr holds its last value.
  - hs0 = !(hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)).
  - vs0 = !(vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)).
- Stage 1: vis, win, hs0, vs0 are registered. The memory registers vaddr on the same edge, so vout corresponds to the stage-1 pixel.
- Stage 2 (output registers):
  - If !vis1: RGB=0, blank=1.
  - If win1: R=vout[14:10], G=vout[9:5], B=vout[4:0]. vout[15] is ignored.
  - Otherwise: RGB=border, blank=0.
  - vga_hs, vga_vs, blank are registered stage-1 values.
- Latency: the pixel for counter position (h,v) appears on the outputs exactly 2 vclk later. Sync and blank carry the same 2-cycle delay, so all outputs are mutually aligned.
- frame_start = 1 for the single cycle in which the outputs present pixel (0,0).
- en=0: the pipeline continues to shift with vis forced to 0. After 2 cycles, outputs are blank with hs=vs=1. Counters resume from their held values when en returns to 1.
- Address bound: row max 119, so the maximum vaddr is 16'hFBFF. The block never addresses above it.

Decomposition:
- Shared package:
  - VGA 640x480 timing constants (default values above)
  - IMG_W=128, IMG_H=120, SCALE_LOG2=2
  - VRAM_BASE=2'b11
  - pixel field positions (R 14:10, G 9:5, B 4:0)
- Sub-module vga_timing: counters, en hold, stage-0 vis/hs/vs decode.
- vga_scanout adds address generation, the alignment pipeline and colour muxing.

Test Plan:
- Reset release, en=1, vout tied to 16'h7FFF, run one frame:
  - 800 cycles between hs falling edges
  - hs low 96 cycles, first fall at cycle 658 after release (hcnt 656 + 2)
  - vs low exactly 1600 cycles; frame period 420000 cycles
- VRAM model with data = address:
  - pixel (64,0) → RGB from word 0xC000
  - pixel (68,0) → word 0xC001
  - pixel (575,479) → word 0xFBFF
  - each value appears 2 cycles after its counter position
- border=15'h1234, image all zero:
  - columns 0–63 and 576–639 output R=0x04, G=0x11, B=0x14 with blank=0
  - columns 64–575 output 0
- Drop en for 100 cycles mid-line at hcnt=300:
  - outputs blank within 2 cycles
  - on re-enable, the next pixel is column 300 with correct address
- Assert rst mid-frame (vcnt=200): outputs immediately take reset values with no vclk edge needed; after release, the next frame_start follows exactly 420000 cycles later, counted from the hcnt=0,vcnt=0 restart.

Source files
------------

// File: rtl/vga_scanout_pkg.sv
// rtl/vga_scanout_pkg.sv - VGA timing, framebuffer geometry and pixel-format constants
package vga_scanout_pkg;

    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_IMG_X_OFF = 64;

    localparam int IMG_W      = 128;
    localparam int IMG_H      = 120;
    localparam int SCALE_LOG2 = 2;
    localparam int IMG_X_SPAN = IMG_W << SCALE_LOG2;

    localparam logic [1:0] VRAM_BASE = 2'b11;

    localparam int R_HI = 14;
    localparam int R_LO = 10;
    localparam int G_HI = 9;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb_t;

    function automatic rgb_t word_to_rgb(input logic [14:0] w);
        rgb_t p;
        p.r = w[R_HI:R_LO];
        p.g = w[G_HI:G_LO];
        p.b = w[B_HI:B_LO];
        return p;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel/line counters with enable hold and stage-0 visible/sync decode
module vga_timing
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    output logic [9:0] o_hcnt,
    output logic [9:0] o_vcnt,
    output logic       o_vis,
    output logic       o_hs,
    output logic       o_vs
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       w_hwrap;

    assign w_hwrap = (r_hcnt == H_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_en) begin
            r_hcnt <= w_hwrap ? 10'd0 : r_hcnt + 10'd1;
            if (w_hwrap) begin
                r_vcnt <= (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
            end
        end
    end

    // A disabled scan looks like blanking with both syncs idle.
    assign o_vis  = i_en && (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    assign o_hs   = !(i_en && (r_hcnt >= HS_START) && (r_hcnt < HS_END));
    assign o_vs   = !(i_en && (r_vcnt >= VS_START) && (r_vcnt < VS_END));
    assign o_hcnt = r_hcnt;
    assign o_vcnt = r_vcnt;

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA scanout: VRAM address generation, 2-stage alignment pipe, colour mux
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int IMG_X_OFF = VGA_IMG_X_OFF
) (
    input  logic        vclk,
    input  logic        rst,
    input  logic        en,
    input  logic [14:0] border,
    output logic [15:0] vaddr,
    input  logic [15:0] vout,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [4:0]  vga_r,
    output logic [4:0]  vga_g,
    output logic [4:0]  vga_b,
    output logic        blank,
    output logic        frame_start
);

    localparam int         COL_W = $clog2(IMG_W);
    localparam int         ROW_W = $clog2(IMG_H);
    localparam logic [9:0] X_LO  = 10'(IMG_X_OFF);
    localparam logic [9:0] X_HI  = 10'(IMG_X_OFF + IMG_X_SPAN);

    logic [9:0]       w_hcnt;
    logic [9:0]       w_vcnt;
    logic [9:0]       w_hoff;
    logic             w_vis;
    logic             w_hs0;
    logic             w_vs0;
    logic             w_win;
    logic             w_first;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [15:0]      w_vaddr;
    rgb_t             w_pix;
    logic             w_unused_bits;

    logic [15:0] r_vaddr;
    logic        r_vis1, r_win1, r_hs1, r_vs1, r_fs1;
    logic        r_hs2, r_vs2, r_blank2, r_fs2;
    rgb_t        r_pix;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk   (vclk),
        .i_rst_n (rst),
        .i_en    (en),
        .o_hcnt  (w_hcnt),
        .o_vcnt  (w_vcnt),
        .o_vis   (w_vis),
        .o_hs    (w_hs0),
        .o_vs    (w_vs0)
    );

    assign w_hoff  = w_hcnt - X_LO;
    assign w_col   = w_hoff[SCALE_LOG2 +: COL_W];
    assign w_row   = w_vcnt[SCALE_LOG2 +: ROW_W];
    assign w_win   = w_vis && (w_hcnt >= X_LO) && (w_hcnt < X_HI);
    assign w_first = w_vis && (w_hcnt == 10'd0) && (w_vcnt == 10'd0);

    // VRAM registers the address itself, so vaddr must be combinational to land data in stage 1.
    assign w_vaddr = w_win ? {VRAM_BASE, w_row, w_col} : r_vaddr;
    assign vaddr   = w_vaddr;

    assign w_unused_bits = &{1'b0, vout[15], w_hoff[9], w_hoff[1:0], w_vcnt[9], w_vcnt[1:0]};

    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            r_vaddr <= {VRAM_BASE, 14'd0};
            r_vis1  <= 1'b0;
            r_win1  <= 1'b0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
            r_fs1   <= 1'b0;
        end else begin
            r_vaddr <= w_vaddr;
            r_vis1  <= w_vis;
            r_win1  <= w_win;
            r_hs1   <= w_hs0;
            r_vs1   <= w_vs0;
            r_fs1   <= w_first;
        end
    end

    always_comb begin
        w_pix = '0;
        if (r_vis1) begin
            w_pix = r_win1 ? word_to_rgb(vout[14:0]) : rgb_t'(border);
        end
    end

    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            r_pix    <= '0;
            r_hs2    <= 1'b1;
            r_vs2    <= 1'b1;
            r_blank2 <= 1'b1;
            r_fs2    <= 1'b0;
        end else begin
            r_pix    <= w_pix;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_blank2 <= !r_vis1;
            r_fs2    <= r_fs1;
        end
    end

    assign vga_r       = r_pix.r;
    assign vga_g       = r_pix.g;
    assign vga_b       = r_pix.b;
    assign vga_hs      = r_hs2;
    assign vga_vs      = r_vs2;
    assign blank       = r_blank2;
    assign frame_start = r_fs2;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - randomized scoreboard bench for vga_scanout (vertically shortened frame)
module tb_vga_scanout;

    localparam int VA    = 12;
    localparam int VFP   = 2;
    localparam int VSW   = 2;
    localparam int VBP   = 2;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int HT    = 800;
    localparam int FRAME = HT * VT;

    logic        vclk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [14:0] border = 15'h0;
    logic [15:0] vaddr;
    logic [15:0] vout = 16'h0;
    logic        vga_hs, vga_vs, blank, frame_start;
    logic [4:0]  vga_r, vga_g, vga_b;

    vga_scanout #(
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSW),
        .V_BP     (VBP)
    ) dut (
        .vclk        (vclk),
        .rst         (rst),
        .en          (en),
        .border      (border),
        .vaddr       (vaddr),
        .vout        (vout),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .blank       (blank),
        .frame_start (frame_start)
    );

    always #5 vclk = ~vclk;

    // VRAM contents: 0 = data equals address, 1 = all zero, 2 = all white
    int mem_mode = 2;

    function automatic logic [15:0] vram_word(input logic [15:0] a);
        case (mem_mode)
            0:       return a;
            1:       return 16'h0000;
            default: return 16'h7FFF;
        endcase
    endfunction

    always @(posedge vclk) vout <= vram_word(vaddr);

    typedef struct {
        int          due;
        int          h;
        int          v;
        logic [18:0] outv;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edges = 0;
    int   rel_edge = 0;
    bit   mon_on = 1'b0;
    bit   rand_bd = 1'b0;
    int   mh = 0;
    int   mv = 0;

    int   first_fall, last_fall, per_min, per_max, wid_min, wid_max, vs_fall, vs_low;
    logic prev_hs, prev_vs;
    int   fs_t[$];

    // Reference: what the screen shows at raster position (h,v), {hs, vs, blank, fs, rgb}.
    function automatic logic [18:0] model_out(input int h, input int v, input bit e,
                                              input logic [14:0] bd);
        bit          vis, win, hs, vs, fs;
        logic [14:0] rgb;
        logic [15:0] addr, w;
        vis = e && h < 640 && v < VA;
        win = vis && h >= 64 && h < 576;
        hs  = !(e && h >= 656 && h < 752);
        vs  = !(e && v >= VA + VFP && v < VA + VFP + VSW);
        fs  = vis && h == 0 && v == 0;
        rgb = 15'h0;
        if (win) begin
            addr = 16'hC000 + 16'((v / 4) * 128 + (h - 64) / 4);
            w    = vram_word(addr);
            rgb  = w[14:0];
        end else if (vis) begin
            rgb = bd;
        end
        return {hs, vs, !vis, fs, rgb};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hs"}, int'(vga_hs), 1);
        chk({tag, "_vs"}, int'(vga_vs), 1);
        chk({tag, "_blank"}, int'(blank), 1);
        chk({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
        chk({tag, "_vaddr"}, int'(vaddr), 32'hC000);
    endtask

    task automatic trk_reset();
        first_fall = -1; last_fall = 0;
        per_min = 1 << 30; per_max = -1;
        wid_min = 1 << 30; wid_max = -1;
        vs_fall = -1; vs_low = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
        fs_t.delete();
    endtask

    task automatic cycle(input bit e);
        exp_t x;
        en = e;
        if (rand_bd && mh == 700) border = 15'($urandom);
        x.due  = edges + 2;
        x.h    = mh;
        x.v    = mv;
        x.outv = model_out(mh, mv, e, border);
        q.push_back(x);
        if (e) begin
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1 == VT) ? 0 : mv + 1;
            end
        end
        @(negedge vclk);
    endtask

    task automatic release_rst();
        rst = 1'b1;
        rel_edge = edges;
        mh = 0;
        mv = 0;
        q.delete();
        trk_reset();
        mon_on = 1'b1;
    endtask

    initial begin : monitor
        exp_t        x;
        logic [18:0] got;
        int          t;
        forever begin
            @(posedge vclk);
            edges++;
            #1;
            if (mon_on) begin
                while (q.size() > 0 && q[0].due <= edges) begin
                    x   = q.pop_front();
                    got = {vga_hs, vga_vs, blank, frame_start, vga_r, vga_g, vga_b};
                    checks++;
                    if (x.due != edges || got !== x.outv) begin
                        errors++;
                        if (errors <= 20)
                            $display("FAIL pixel h=%0d v=%0d due=%0d at=%0d got=%h exp=%h",
                                     x.h, x.v, x.due, edges, got, x.outv);
                    end
                end
                t = edges - rel_edge;
                if (prev_hs && !vga_hs) begin
                    if (first_fall < 0) first_fall = t;
                    else begin
                        if (t - last_fall < per_min) per_min = t - last_fall;
                        if (t - last_fall > per_max) per_max = t - last_fall;
                    end
                    last_fall = t;
                end
                if (!prev_hs && vga_hs) begin
                    if (t - last_fall < wid_min) wid_min = t - last_fall;
                    if (t - last_fall > wid_max) wid_max = t - last_fall;
                end
                if (prev_vs && !vga_vs) vs_fall = t;
                if (!prev_vs && vga_vs && vs_low < 0) vs_low = t - vs_fall;
                if (frame_start) fs_t.push_back(t);
                prev_hs = vga_hs;
                prev_vs = vga_vs;
            end
        end
    end

    initial begin : stimulus
        bit dropped;
        dropped = 1'b0;
        trk_reset();
        #2 rst = 1'b0;
        #1 chk_reset("por");
        repeat (3) @(negedge vclk);

        mem_mode = 2;
        rand_bd  = 1'b1;
        release_rst();
        repeat (FRAME + 700) cycle(1'b1);
        chk("hs_first_fall", first_fall, 658);
        chk("hs_period_min", per_min, 800);
        chk("hs_period_max", per_max, 800);
        chk("hs_low_min", wid_min, 96);
        chk("hs_low_max", wid_max, 96);
        chk("vs_low", vs_low, 1600);
        chk("fs_count", fs_t.size(), 2);
        if (fs_t.size() >= 2) begin
            chk("fs_first", fs_t[0], 2);
            chk("frame_period", fs_t[1] - fs_t[0], FRAME);
        end

        // Address-as-data image with random enable gaps and one long gap mid-line.
        mem_mode = 0;
        for (int k = 0; k < 4 * FRAME && mv != VA; k++) begin
            if (mv == 1 && mh == 300 && !dropped) begin
                dropped = 1'b1;
                repeat (100) cycle(1'b0);
            end else if ($urandom_range(0, 63) == 0) begin
                repeat ($urandom_range(1, 4)) cycle(1'b0);
            end else begin
                cycle(1'b1);
            end
        end
        for (int k = 0; k < HT && mh != 700; k++) cycle(1'b1);

        mem_mode = 1;
        rand_bd  = 1'b0;
        border   = 15'h1234;
        for (int k = 0; k < 2 * FRAME && mv != 0; k++) cycle(1'b1);
        for (int k = 0; k < 2 * FRAME && mv != 3; k++) cycle(1'b1);
        for (int k = 0; k < 2 * FRAME && !(mv == 10 && mh == 300); k++) cycle(1'b1);

        mon_on = 1'b0;
        q.delete();
        #3 rst = 1'b0;
        #1 chk_reset("mid");
        repeat (3) @(negedge vclk);
        release_rst();
        repeat (FRAME + 200) cycle(1'b1);
        chk("rst_fs_count", fs_t.size(), 2);
        if (fs_t.size() >= 2) begin
            chk("rst_fs_first", fs_t[0], 2);
            chk("rst_frame_period", fs_t[1] - fs_t[0], FRAME);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
